// File: rtl/led_mode_controller.sv
// led_mode_controller
//   Front-panel controller for four board LEDs. Each raw push switch is
//   debounced, and each debounced release becomes a pending event. A
//   fixed-priority arbiter serves one pending event per clock, lowest index
//   first. A mode FSM consumes the grants and drives the LEDs in TOGGLE,
//   CHASE or BLINK mode.
//
//   Parameters
//     DEBOUNCE_LIMIT  clocks a raw level must stay stable before acceptance (>=2)
//     STEP_COUNT      clocks per chase/blink step (>=2)
//
//   Ports
//     i_Clk               system clock, posedge
//     i_Rst               synchronous reset, active high
//     i_Switch_1..4       raw switches, 1 = pressed (1 highest priority,
//                         4 lowest and also the mode advance)
//     o_LED_1..4          registered LED drives
//     o_Mode              registered mode: 00 TOGGLE, 01 CHASE, 10 BLINK
//     o_Grant [3:0]       only with LED_CTRL_GRANT_EN defined: registered
//                         one-hot copy of the grant, high in the cycle its
//                         effect shows on o_LED_*/o_Mode
//
//   Switch inputs are expected to be synchronous to i_Clk.

module led_debounce_lane #(
  parameter int LIMIT = 4
) (
  input  logic gclk,
  input  logic rst,
  input  logic raw,
  output logic fall
);
  localparam int CW = $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  always_ff @(posedge gclk) begin
    if (rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // One-cycle pulse in the cycle after the debounced level drops.
  assign fall = level_d & ~level;
endmodule

module led_mode_controller #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int STEP_COUNT     = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
`ifdef LED_CTRL_GRANT_EN
  ,
  output logic [3:0] o_Grant
`endif
);
  localparam int NUM_SW = 4;
  localparam int SW = $clog2(STEP_COUNT);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_COUNT - 1);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_BLINK  = 2'b10
  } mode_t;

  logic [NUM_SW-1:0] raw, fall, pend, pend_nxt, grant;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  generate
    for (genvar n = 0; n < NUM_SW; n++) begin : g_lane
      led_debounce_lane #(.LIMIT(DEBOUNCE_LIMIT)) u_lane (
        .gclk (i_Clk),
        .rst  (i_Rst),
        .raw  (raw[n]),
        .fall (fall[n])
      );
    end
  endgenerate

  // Isolate the lowest set pending bit. A new event on the granted bit
  // re-sets it because the OR comes after the clear.
  assign grant    = pend & (~pend + NUM_SW'(1));
  assign pend_nxt = (pend & ~grant) | fall;

  mode_t             mode, mode_nxt;
  logic [NUM_SW-1:0] led, led_nxt;
  logic [SW-1:0]     cnt, cnt_nxt;
  logic              dir_dn, dir_dn_nxt;
  logic              pause, pause_nxt;
  logic              counting, tick;

  assign counting = ((mode == MODE_CHASE) && !pause) || (mode == MODE_BLINK);
  assign tick     = counting && (cnt == STEP_LAST);

  always_comb begin
    mode_nxt   = mode;
    led_nxt    = led;
    dir_dn_nxt = dir_dn;
    pause_nxt  = pause;
    cnt_nxt    = cnt;

    if (mode == MODE_TOGGLE)  cnt_nxt = '0;
    else if (counting)        cnt_nxt = tick ? '0 : cnt + SW'(1);

    if (grant[3]) begin
      // Mode change wins over any tick in the same cycle.
      cnt_nxt = '0;
      case (mode)
        MODE_TOGGLE: begin
          mode_nxt   = MODE_CHASE;
          led_nxt    = 4'b0001;
          dir_dn_nxt = 1'b0;
          pause_nxt  = 1'b0;
        end
        MODE_CHASE: begin
          mode_nxt = MODE_BLINK;
          led_nxt  = 4'b1111;
        end
        default: begin
          mode_nxt = MODE_TOGGLE;
          led_nxt  = 4'b0000;
        end
      endcase
    end else begin
      case (mode)
        MODE_TOGGLE: led_nxt = led ^ {1'b0, grant[2:0]};
        MODE_CHASE: begin
          // Grant first, so a same-cycle tick sees the new direction/pause.
          if (grant[0]) dir_dn_nxt = ~dir_dn;
          if (grant[1]) pause_nxt  = ~pause;
          if (tick && !pause_nxt)
            led_nxt = dir_dn_nxt ? {led[0], led[3:1]} : {led[2:0], led[3]};
        end
        MODE_BLINK: if (tick) led_nxt = ~led;
        default: begin
          mode_nxt = MODE_TOGGLE;
          led_nxt  = '0;
        end
      endcase
    end
  end

`ifdef LED_CTRL_GRANT_EN
  logic [NUM_SW-1:0] grant_q;
  assign o_Grant = grant_q;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      mode    <= MODE_TOGGLE;
      led     <= '0;
      cnt     <= '0;
      dir_dn  <= 1'b0;
      pause   <= 1'b0;
      pend    <= '0;
`ifdef LED_CTRL_GRANT_EN
      grant_q <= '0;
`endif
    end else begin
      mode    <= mode_nxt;
      led     <= led_nxt;
      cnt     <= cnt_nxt;
      dir_dn  <= dir_dn_nxt;
      pause   <= pause_nxt;
      pend    <= pend_nxt;
`ifdef LED_CTRL_GRANT_EN
      grant_q <= grant;
`endif
    end
  end

  assign o_LED_1 = led[0];
  assign o_LED_2 = led[1];
  assign o_LED_3 = led[2];
  assign o_LED_4 = led[3];
  assign o_Mode  = mode;
endmodule

// File: tb/tb_led_mode_controller.sv
// Bench for led_mode_controller with DEBOUNCE_LIMIT=4, STEP_COUNT=8.
// Directed table, hand sequences for exact latency/ordering, then random
// switch activity checked every cycle against a behavioural model.
module tb_led_mode_controller;
  localparam int DL = 4;
  localparam int SC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] sw  = 4'hF;
  logic       led1, led2, led3, led4;
  logic [1:0] mode;
  logic [3:0] led;
`ifdef LED_CTRL_GRANT_EN
  logic [3:0] grant;
`endif
  assign led = {led4, led3, led2, led1};

  int checks   = 0;
  int failures = 0;

  led_mode_controller #(.DEBOUNCE_LIMIT(DL), .STEP_COUNT(SC)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Switch_1 (sw[0]),
    .i_Switch_2 (sw[1]),
    .i_Switch_3 (sw[2]),
    .i_Switch_4 (sw[3]),
    .o_LED_1    (led1),
    .o_LED_2    (led2),
    .o_LED_3    (led3),
    .o_LED_4    (led4),
    .o_Mode     (mode)
`ifdef LED_CTRL_GRANT_EN
    ,
    .o_Grant    (grant)
`endif
  );

  // ---------------- behavioural model ----------------
  // Debounce: a switch's level flips once its last DL samples all disagree
  // with it. LEDs are derived from per-mode abstract state.
  logic [DL-1:0] m_hist [4];
  logic [3:0]    m_deb, m_arr, m_pend, m_grant, m_tog;
  logic [1:0]    m_mode;
  int            m_pos, m_dir, m_tcnt;
  bit            m_paused, m_on;

  function automatic logic [3:0] m_led();
    case (m_mode)
      2'd0:    return m_tog;
      2'd1:    return 4'(1 << m_pos);
      default: return m_on ? 4'hF : 4'h0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
    m_deb = '0; m_arr = '0; m_pend = '0; m_grant = '0; m_tog = '0;
    m_mode = 2'd0; m_pos = 0; m_dir = 1; m_tcnt = 0; m_paused = 0; m_on = 0;
  endfunction

  function automatic void model_step();
    int g;
    bit run, tk;
    logic [3:0] fl;
    if (rst) begin
      model_reset();
      return;
    end
    g = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) g = i;
    m_grant = (g >= 0) ? 4'(1 << g) : 4'h0;
    run = (m_mode == 2'd1 && !m_paused) || m_mode == 2'd2;
    tk  = run && (m_tcnt == SC - 1);
    if (m_mode == 2'd0) m_tcnt = 0;
    else if (run)       m_tcnt = (m_tcnt + 1) % SC;
    if (g == 3) begin
      m_mode = (m_mode == 2'd2) ? 2'd0 : m_mode + 2'd1;
      m_tcnt = 0; m_tog = '0; m_pos = 0; m_dir = 1; m_paused = 0; m_on = 1;
    end else begin
      case (m_mode)
        2'd0: if (g >= 0) m_tog[g] = ~m_tog[g];
        2'd1: begin
          if (g == 0) m_dir = -m_dir;
          if (g == 1) m_paused = !m_paused;
          if (tk && !m_paused) m_pos = (m_pos + m_dir + 4) % 4;
        end
        default: if (tk) m_on = !m_on;
      endcase
    end
    if (g >= 0) m_pend[g] = 1'b0;
    m_pend = m_pend | m_arr;
    fl = '0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = {m_hist[i][DL-2:0], sw[i]};
      if (m_hist[i] == {DL{~m_deb[i]}}) begin
        fl[i]    = m_deb[i];
        m_deb[i] = ~m_deb[i];
      end
    end
    m_arr = fl;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: model advances at the edge, outputs compared at negedge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_led", led, m_led());
    chk("model_mode", {2'b00, mode}, {2'b00, m_mode});
`ifdef LED_CTRL_GRANT_EN
    chk("model_grant", grant, m_grant);
`endif
  endtask

  typedef struct {
    bit         r;
    logic [3:0] s;
    int         n;
    logic [3:0] led;
    logic [1:0] mode;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, logic [3:0] s, int n, logic [3:0] l, logic [1:0] m);
    vec_t v;
    v.r = r; v.s = s; v.n = n; v.led = l; v.mode = m;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // reset, glitch, toggle
    add(1, 4'hF,  2, 4'b0000, 2'b00);
    add(0, 4'h0, 10, 4'b0000, 2'b00);
    add(0, 4'h1,  3, 4'b0000, 2'b00);
    add(0, 4'h0, 10, 4'b0000, 2'b00);
    add(0, 4'h1, 10, 4'b0000, 2'b00);
    add(0, 4'h0, 10, 4'b0001, 2'b00);
    add(0, 4'h1, 10, 4'b0001, 2'b00);
    add(0, 4'h0, 10, 4'b0000, 2'b00);
    add(0, 4'h5, 10, 4'b0000, 2'b00);
    add(0, 4'h0, 10, 4'b0101, 2'b00);
    // enter CHASE, rotation, direction flip on a tick cycle, pause on a tick cycle
    add(0, 4'h8, 10, 4'b0101, 2'b00);
    add(0, 4'h0,  5, 4'b0101, 2'b00);
    add(0, 4'h0,  1, 4'b0001, 2'b01);
    add(0, 4'h0,  8, 4'b0010, 2'b01);
    add(0, 4'h0,  8, 4'b0100, 2'b01);
    add(0, 4'h1, 10, 4'b1000, 2'b01);
    add(0, 4'h0,  6, 4'b0100, 2'b01);
    add(0, 4'h0,  8, 4'b0010, 2'b01);
    add(0, 4'h2, 10, 4'b0001, 2'b01);
    add(0, 4'h0,  6, 4'b0001, 2'b01);
    add(0, 4'h0, 32, 4'b0001, 2'b01);
    add(0, 4'h2, 10, 4'b0001, 2'b01);
    add(0, 4'h0,  6, 4'b0001, 2'b01);
    add(0, 4'h0,  7, 4'b0001, 2'b01);
    add(0, 4'h0,  1, 4'b1000, 2'b01);
    // BLINK entered on a tick cycle, grant 1 ignored, back to TOGGLE
    add(0, 4'h8, 10, 4'b0100, 2'b01);
    add(0, 4'h0,  6, 4'b1111, 2'b10);
    add(0, 4'h0,  7, 4'b1111, 2'b10);
    add(0, 4'h0,  1, 4'b0000, 2'b10);
    add(0, 4'h0,  8, 4'b1111, 2'b10);
    add(0, 4'h1, 10, 4'b0000, 2'b10);
    add(0, 4'h0,  6, 4'b1111, 2'b10);
    add(0, 4'h8, 10, 4'b0000, 2'b10);
    add(0, 4'h0,  6, 4'b0000, 2'b00);
    add(0, 4'h0, 20, 4'b0000, 2'b00);
    // reset in CHASE while a switch 2 event is pending
    add(0, 4'h8, 10, 4'b0000, 2'b00);
    add(0, 4'h0,  6, 4'b0001, 2'b01);
    add(0, 4'h2, 10, 4'b0010, 2'b01);
    add(0, 4'h0,  5, 4'b0010, 2'b01);
    add(1, 4'h0,  1, 4'b0000, 2'b00);
    add(0, 4'h0, 20, 4'b0000, 2'b00);

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      sw  = tbl[i].s;
      repeat (tbl[i].n) cyc();
      chk($sformatf("vec%0d_led", i), led, tbl[i].led);
      chk($sformatf("vec%0d_mode", i), {2'b00, mode}, {2'b00, tbl[i].mode});
    end

    // Exact latency: LED1 flips on the 6th edge after the raw release
    // (4 edges to debounce, 1 to pend, 1 to apply).
    sw = 4'h1;
    repeat (10) cyc();
    sw = 4'h0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk($sformatf("lat_k%0d", k), led, (k < 6) ? 4'b0000 : 4'b0001);
`ifdef LED_CTRL_GRANT_EN
      chk($sformatf("lat_grant_k%0d", k), grant, (k == 6) ? 4'b0001 : 4'b0000);
`endif
    end

    // Simultaneous release of 1 and 3: LED1 at N, LED3 at N+1.
    sw = 4'h5;
    repeat (10) cyc();
    sw = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("pri_k%0d", k), led,
          (k < 6) ? 4'b0001 : (k == 6) ? 4'b0000 : 4'b0100);
`ifdef LED_CTRL_GRANT_EN
      chk($sformatf("pri_grant_k%0d", k), grant,
          (k == 6) ? 4'b0001 : (k == 7) ? 4'b0100 : 4'b0000);
`endif
    end

    // Random switch activity, occasional reset; model compared every cycle.
    for (int seg = 0; seg < 400; seg++) begin
      int n;
      rst = ($urandom_range(0, 49) == 0);
      sw  = 4'($urandom);
      n   = rst ? 1 : int'($urandom_range(1, 12));
      repeat (n) cyc();
    end
    rst = 1'b0;
    sw  = 4'h0;
    repeat (20) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
